// File: rtl/rtc_slew_trig.sv
// rtc_slew_trig: free-running ns/sec time base. A delta-sigma residue keeps
// the long-run rate equal to the full-precision period. A bounded slewer
// absorbs a signed ns offset without letting time step backwards. Also
// generates a one-pps pulse and an absolute-time trigger.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no offset pending, slew amount is zero
// SLEW    | absorbing remaining offset R, at most slew_step ns per clock
// DONE    | offset fully absorbed, slew_done high for this one cycle
//
// FRAC_W must be smaller than PER_FRAC_W, and PPS_CYC must be at least 1.
module rtc_slew_trig #(
  parameter int FRAC_W     = 8,
  parameter int PER_FRAC_W = 32,
  parameter int SEC_W      = 48,
  parameter int PPS_CYC    = 4,
  parameter int NS_MODULO  = 1_000_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  time_ld,
  input  logic [30+FRAC_W-1:0]  time_ns_in,
  input  logic [SEC_W-1:0]      time_sec_in,
  input  logic                  period_ld,
  input  logic [8+PER_FRAC_W-1:0] period_in,
  input  logic                  slew_ld,
  input  logic [31:0]           slew_offset,
  input  logic [7:0]            slew_step,
  output logic                  slew_busy,
  output logic                  slew_done,
  input  logic                  trig_ld,
  input  logic [SEC_W-1:0]      trig_sec,
  input  logic [29:0]           trig_ns,
  output logic                  trig_hit,
  output logic [30+FRAC_W-1:0]  time_ns,
  output logic [SEC_W-1:0]      time_sec,
  output logic [31:0]           time_ptp_ns,
  output logic [SEC_W-1:0]      time_ptp_sec,
  output logic                  pps
);

  localparam int TNS_W = 30 + FRAC_W;
  localparam int P_W   = 8 + PER_FRAC_W;
  localparam int RES_W = PER_FRAC_W - FRAC_W;
  localparam int INC_W = 8 + FRAC_W;
  localparam int SUM_W = TNS_W + 2;
  localparam int CNT_W = $clog2(PPS_CYC + 1);
  localparam logic [SUM_W-1:0] MOD_FR = SUM_W'(NS_MODULO) << FRAC_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLEW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [P_W-1:0]    p_reg;
  logic [RES_W-1:0]  residue;
  logic [RES_W:0]    res_sum;
  logic              ds_carry;
  logic [CNT_W-1:0]  pps_cnt;
  logic [1:0]        state;
  logic signed [32:0] r_reg;
  logic signed [32:0] r_next;
  logic [32:0]       r_abs;
  logic [7:0]        cap;
  logic [7:0]        pns;
  logic [7:0]        neg_lim;
  logic [7:0]        neg_mag;
  logic signed [8:0] slew_s;
  logic [SUM_W-1:0]  inc_fr;
  logic [SUM_W-1:0]  sum_fr;
  logic [SUM_W-1:0]  sum_wrapped;
  logic              wrap;
  logic [SEC_W-1:0]  trig_sec_r;
  logic [29:0]       trig_ns_r;
  logic              armed;
  logic              time_ge;

  // Slew amount for this clock: positive offsets capped by slew_step,
  // negative ones also capped below the period so time never goes backwards.
  always_comb begin
    r_abs   = r_reg[32] ? (33'd0 - r_reg) : r_reg;
    cap     = (r_abs > 33'(slew_step)) ? slew_step : r_abs[7:0];
    pns     = p_reg[P_W-1 -: 8];
    neg_lim = (pns == 8'd0) ? 8'd0 : pns - 8'd1;
    neg_mag = (cap < neg_lim) ? cap : neg_lim;
    slew_s  = '0;
    if (state == ST_SLEW) begin
      if (r_reg > 33'sd0)
        slew_s = $signed({1'b0, cap});
      else if (r_reg < 33'sd0)
        slew_s = -$signed({1'b0, neg_mag});
    end
    r_next = r_reg - 33'(slew_s);
  end

  // Per-clock increment in FRAC_W units; the sum is computed modulo 2^SUM_W
  // since the true increment is never negative.
  always_comb begin
    res_sum     = {1'b0, residue} + {1'b0, p_reg[RES_W-1:0]};
    ds_carry    = res_sum[RES_W];
    inc_fr      = SUM_W'(p_reg[P_W-1 -: INC_W]) + SUM_W'(ds_carry)
                + (SUM_W'(slew_s) << FRAC_W);
    sum_fr      = {2'b00, time_ns} + inc_fr;
    wrap        = (sum_fr >= MOD_FR);
    sum_wrapped = sum_fr - MOD_FR;
  end

  // Time base, period register, residue and pps width counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg    <= '0;
      residue  <= '0;
      time_ns  <= '0;
      time_sec <= '0;
      pps_cnt  <= '0;
    end else begin
      if (period_ld)
        p_reg <= period_in;
      if (time_ld) begin
        time_ns  <= time_ns_in;
        time_sec <= time_sec_in;
        if (pps_cnt != '0)
          pps_cnt <= pps_cnt - CNT_W'(1);
      end else begin
        residue <= res_sum[RES_W-1:0];
        if (wrap) begin
          time_ns  <= sum_wrapped[TNS_W-1:0];
          time_sec <= time_sec + SEC_W'(1);
          pps_cnt  <= CNT_W'(PPS_CYC);
        end else begin
          time_ns <= sum_fr[TNS_W-1:0];
          if (pps_cnt != '0)
            pps_cnt <= pps_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Slew FSM; a time load aborts any slew silently and wins over slew_ld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      r_reg <= '0;
    end else if (time_ld) begin
      state <= ST_IDLE;
      r_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (slew_ld) begin
            r_reg <= {slew_offset[31], slew_offset};
            state <= (slew_offset == 32'd0) ? ST_DONE : ST_SLEW;
          end
        end
        ST_SLEW: begin
          if (slew_ld) begin
            r_reg <= {slew_offset[31], slew_offset};
            state <= (slew_offset == 32'd0) ? ST_DONE : ST_SLEW;
          end else begin
            r_reg <= r_next;
            if (r_next == 33'sd0)
              state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign time_ge = (time_sec > trig_sec_r) ||
                   ((time_sec == trig_sec_r) && (time_ns[TNS_W-1:FRAC_W] >= trig_ns_r));

  // Trigger: a fresh target is armed without evaluating it in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sec_r <= '0;
      trig_ns_r  <= '0;
      armed      <= 1'b0;
      trig_hit   <= 1'b0;
    end else if (trig_ld) begin
      trig_sec_r <= trig_sec;
      trig_ns_r  <= trig_ns;
      armed      <= 1'b1;
      trig_hit   <= 1'b0;
    end else if (armed && time_ge) begin
      armed    <= 1'b0;
      trig_hit <= 1'b1;
    end else begin
      trig_hit <= 1'b0;
    end
  end

  assign time_ptp_ns  = {2'b00, time_ns[TNS_W-1:FRAC_W]};
  assign time_ptp_sec = time_sec;
  assign pps          = (pps_cnt != '0);
  assign slew_busy    = (state == ST_SLEW);
  assign slew_done    = (state == ST_DONE);

endmodule
